// File: rtl/wasm_imm_decoder_pkg.sv
// Shared definitions for the immediate decoder and the CPU: mode codes, error
// codes, FSM state encoding and LEB128 length limits.
package wasm_imm_decoder_pkg;

    localparam logic [2:0] IMM_U32 = 3'd0;
    localparam logic [2:0] IMM_S32 = 3'd1;
    localparam logic [2:0] IMM_U64 = 3'd2;
    localparam logic [2:0] IMM_S64 = 3'd3;
    localparam logic [2:0] IMM_F32 = 3'd4;
    localparam logic [2:0] IMM_F64 = 3'd5;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_OVERLONG    = 2'd1;
    localparam logic [1:0] ERR_UNUSED_BITS = 2'd2;
    localparam logic [1:0] ERR_BAD_MODE    = 2'd3;

    localparam logic [3:0] LEB_MAX_32 = 4'd5;
    localparam logic [3:0] LEB_MAX_64 = 4'd10;
    localparam logic [3:0] F32_BYTES  = 4'd4;
    localparam logic [3:0] F64_BYTES  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic is_leb_mode(input logic [2:0] m);
        return m <= IMM_S64;
    endfunction

    function automatic logic is_float_mode(input logic [2:0] m);
        return (m == IMM_F32) || (m == IMM_F64);
    endfunction

    function automatic logic [3:0] float_last_index(input logic [2:0] m);
        return (m == IMM_F32) ? (F32_BYTES - 4'd1) : (F64_BYTES - 4'd1);
    endfunction

endpackage

// File: rtl/wasm_imm_decoder_last_byte_check.sv
// leb128_last_byte_check: combinational legality check of the byte at the
// maximum LEB128 length (continuation still set, or illegal unused bits).
module leb128_last_byte_check
    import wasm_imm_decoder_pkg::*;
(
    input  logic [2:0] mode_i,
    input  logic [7:0] byte_i,
    input  logic [3:0] index_i,
    output logic       overlong_o,
    output logic       bad_unused_o
);

    logic at_max;

    always_comb begin
        if ((mode_i == IMM_U64) || (mode_i == IMM_S64)) begin
            at_max = (index_i == (LEB_MAX_64 - 4'd1));
        end else begin
            at_max = (index_i == (LEB_MAX_32 - 4'd1));
        end

        overlong_o   = at_max && byte_i[7];
        bad_unused_o = 1'b0;

        // Unused-bit rules only matter for a properly terminated final byte.
        if (at_max && !byte_i[7]) begin
            case (mode_i)
                IMM_U32: bad_unused_o = |byte_i[6:4];
                IMM_S32: bad_unused_o = (byte_i[6:4] != {3{byte_i[3]}});
                IMM_U64: bad_unused_o = |byte_i[6:1];
                IMM_S64: bad_unused_o = (byte_i != 8'h00) && (byte_i != 8'h7F);
                default: bad_unused_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/wasm_imm_decoder.sv
// Immediate-operand decoder: LEB128 u32/s32/u64/s64 and, when
// WASM_IMM_FLOAT_EN is defined, raw little-endian f32/f64 immediates.
module wasm_imm_decoder
    import wasm_imm_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        busy,
    output logic [63:0] imm,
    output logic        imm_valid,
    output logic [1:0]  error,
    output logic [3:0]  consumed
);

    state_e      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] imm_q, imm_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  consumed_q, consumed_d;
    logic [1:0]  err_q, err_d;

    logic        legal_mode;
    logic [3:0]  cnt_inc;
    logic [6:0]  leb_sh;
    logic [6:0]  ext_sh;
    logic [63:0] leb_acc;
    logic [63:0] ext_mask;
    logic [63:0] leb_val;
    logic        overlong;
    logic        bad_unused;

    leb128_last_byte_check u_last_byte_check (
        .mode_i       (mode_q),
        .byte_i       (byte_data),
        .index_i      (cnt_q),
        .overlong_o   (overlong),
        .bad_unused_o (bad_unused)
    );

`ifdef WASM_IMM_FLOAT_EN
    logic [5:0]  raw_sh;
    logic [63:0] raw_acc;

    always_comb begin
        raw_sh     = {cnt_q[2:0], 3'b000};
        raw_acc    = acc_q | ({56'd0, byte_data} << raw_sh);
        legal_mode = is_leb_mode(mode) || is_float_mode(mode);
    end
`else
    always_comb begin
        legal_mode = is_leb_mode(mode);
    end
`endif

    // Value as it would stand if the current byte terminates the encoding;
    // shifts past bit 63 fall off, which handles the 10th u64/s64 byte.
    always_comb begin
        cnt_inc  = cnt_q + 4'd1;
        leb_sh   = 7'(cnt_q) * 7'd7;
        ext_sh   = leb_sh + 7'd7;
        leb_acc  = acc_q | ({57'd0, byte_data[6:0]} << leb_sh);
        ext_mask = ~((64'd1 << ext_sh) - 64'd1);
        leb_val  = leb_acc;
        if (((mode_q == IMM_S32) || (mode_q == IMM_S64)) && byte_data[6]) begin
            leb_val = leb_acc | ext_mask;
        end
        if ((mode_q == IMM_U32) || (mode_q == IMM_S32)) begin
            leb_val[63:32] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        imm_d      = imm_q;
        cnt_d      = cnt_q;
        consumed_d = consumed_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    acc_d      = '0;
                    imm_d      = '0;
                    cnt_d      = '0;
                    consumed_d = '0;
                    if (legal_mode) begin
                        state_d = ST_COLLECT;
                    end else begin
                        err_d   = ERR_BAD_MODE;
                        state_d = ST_ERR;
                    end
                end
            end

            ST_COLLECT: begin
                if (byte_valid) begin
                    cnt_d = cnt_inc;
`ifdef WASM_IMM_FLOAT_EN
                    if (is_float_mode(mode_q)) begin
                        acc_d = raw_acc;
                        if (cnt_q == float_last_index(mode_q)) begin
                            imm_d      = raw_acc;
                            consumed_d = cnt_inc;
                            state_d    = ST_DONE;
                        end
                    end else
`endif
                    begin
                        acc_d = leb_acc;
                        if (overlong) begin
                            imm_d      = '0;
                            consumed_d = cnt_inc;
                            err_d      = ERR_OVERLONG;
                            state_d    = ST_ERR;
                        end else if (bad_unused) begin
                            imm_d      = '0;
                            consumed_d = cnt_inc;
                            err_d      = ERR_UNUSED_BITS;
                            state_d    = ST_ERR;
                        end else if (!byte_data[7]) begin
                            imm_d      = leb_val;
                            consumed_d = cnt_inc;
                            state_d    = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= IMM_U32;
            acc_q      <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
            consumed_q <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
            consumed_q <= consumed_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        byte_ready = (state_q == ST_COLLECT);
        busy       = (state_q != ST_IDLE);
        imm        = imm_q;
        imm_valid  = (state_q == ST_DONE);
        error      = (state_q == ST_ERR) ? err_q : ERR_NONE;
        consumed   = consumed_q;
    end

endmodule

// File: tb/tb_wasm_imm_decoder.sv
// Directed self-checking bench for wasm_imm_decoder.
module tb_wasm_imm_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic [63:0] imm;
    logic        imm_valid;
    logic [1:0]  error;
    logic [3:0]  consumed;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  bv [0:15];

    int          pc;
    logic [63:0] o_imm;
    logic [3:0]  o_cons;
    logic [1:0]  o_err;
    logic        o_rdy;
    int          o_acc;

    wasm_imm_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .imm        (imm),
        .imm_valid  (imm_valid),
        .error      (error),
        .consumed   (consumed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one decode (start in cycle 0) and records the pulse cycle and outputs.
    task automatic drive_decode(input logic [2:0] m, input int n, input int gap_at, input int gap_len,
                                output int pulse_cyc, output logic [63:0] r_imm, output logic [3:0] r_cons,
                                output logic [1:0] r_err, output logic r_rdy, output int acc_cnt);
        int idx;
        int gap_left;
        pulse_cyc = -1; r_imm = '0; r_cons = '0; r_err = '0; r_rdy = 1'b0; acc_cnt = 0;
        idx = 0; gap_left = gap_len;
        start = 1'b1; mode = m; byte_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (imm_valid || (error != 2'd0)) begin
                pulse_cyc = cyc; r_imm = imm; r_cons = consumed; r_err = error; r_rdy = byte_ready;
                break;
            end
            if ((idx == gap_at) && (gap_left > 0)) begin
                byte_valid = 1'b0;
                gap_left--;
            end else if (idx < n) begin
                byte_valid = 1'b1;
                byte_data  = bv[idx];
            end else begin
                byte_valid = 1'b0;
            end
            if (byte_valid && byte_ready) begin
                idx++;
                acc_cnt++;
            end
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset byte_ready: got %b want 0", byte_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (imm !== 64'h0) begin n_fail++; $display("FAIL reset imm: got %h want 0", imm); end
        n_cmp++; if (imm_valid !== 1'b0) begin n_fail++; $display("FAIL reset imm_valid: got %b want 0", imm_valid); end
        n_cmp++; if (error !== 2'd0) begin n_fail++; $display("FAIL reset error: got %0d want 0", error); end
        n_cmp++; if (consumed !== 4'd0) begin n_fail++; $display("FAIL reset consumed: got %0d want 0", consumed); end
    endtask

    task automatic test_s32_single();
        bv[0] = 8'h7E;
        drive_decode(3'd1, 1, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (pc !== 2) begin n_fail++; $display("FAIL s32_7E pulse_cycle: got %0d want 2", pc); end
        n_cmp++; if (o_imm !== 64'h00000000_FFFFFFFE) begin n_fail++; $display("FAIL s32_7E imm: got %h want 00000000fffffffe", o_imm); end
        n_cmp++; if (o_cons !== 4'd1) begin n_fail++; $display("FAIL s32_7E consumed: got %0d want 1", o_cons); end
        n_cmp++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL s32_7E byte_ready_at_pulse: got %b want 0", o_rdy); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL s32_7E busy_at_pulse: got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s32_7E busy_after: got %b want 0", busy); end
        n_cmp++; if (imm_valid !== 1'b0) begin n_fail++; $display("FAIL s32_7E pulse_width: got %b want 0", imm_valid); end
        tick();
        n_cmp++; if (imm !== 64'h00000000_FFFFFFFE) begin n_fail++; $display("FAIL s32_7E imm_held: got %h want 00000000fffffffe", imm); end
        n_cmp++; if (consumed !== 4'd1) begin n_fail++; $display("FAIL s32_7E consumed_held: got %0d want 1", consumed); end
    endtask

    task automatic test_u32_multi();
        bv[0] = 8'hE5; bv[1] = 8'h8E; bv[2] = 8'h26;
        drive_decode(3'd0, 3, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (pc !== 4) begin n_fail++; $display("FAIL u32_3B pulse_cycle: got %0d want 4", pc); end
        n_cmp++; if (o_imm !== 64'h98765) begin n_fail++; $display("FAIL u32_3B imm: got %h want 98765", o_imm); end
        n_cmp++; if (o_cons !== 4'd3) begin n_fail++; $display("FAIL u32_3B consumed: got %0d want 3", o_cons); end
        tick();
        drive_decode(3'd0, 3, 1, 2, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (pc !== 6) begin n_fail++; $display("FAIL u32_gap pulse_cycle: got %0d want 6", pc); end
        n_cmp++; if (o_imm !== 64'h98765) begin n_fail++; $display("FAIL u32_gap imm: got %h want 98765", o_imm); end
        n_cmp++; if (o_cons !== 4'd3) begin n_fail++; $display("FAIL u32_gap consumed: got %0d want 3", o_cons); end
        tick();
    endtask

    task automatic test_s32_multi();
        bv[0] = 8'hC0; bv[1] = 8'hBB; bv[2] = 8'h78;
        drive_decode(3'd1, 3, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'h00000000_FFFE1DC0) begin n_fail++; $display("FAIL s32_neg imm: got %h want 00000000fffe1dc0", o_imm); end
        n_cmp++; if (o_cons !== 4'd3) begin n_fail++; $display("FAIL s32_neg consumed: got %0d want 3", o_cons); end
        tick();
    endtask

    task automatic test_float();
        bv[0] = 8'h00; bv[1] = 8'h00; bv[2] = 8'h00; bv[3] = 8'hC0;
        drive_decode(3'd4, 4, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
`ifdef WASM_IMM_FLOAT_EN
        n_cmp++; if (o_imm !== 64'h00000000_C0000000) begin n_fail++; $display("FAIL f32 imm: got %h want 00000000c0000000", o_imm); end
        n_cmp++; if (o_cons !== 4'd4) begin n_fail++; $display("FAIL f32 consumed: got %0d want 4", o_cons); end
        n_cmp++; if (pc !== 5) begin n_fail++; $display("FAIL f32 pulse_cycle: got %0d want 5", pc); end
        tick();
        for (int i = 0; i < 7; i++) bv[i] = 8'(i + 1);
        bv[7] = 8'h88;
        drive_decode(3'd5, 8, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'h88070605_04030201) begin n_fail++; $display("FAIL f64 imm: got %h want 8807060504030201", o_imm); end
        n_cmp++; if (o_cons !== 4'd8) begin n_fail++; $display("FAIL f64 consumed: got %0d want 8", o_cons); end
`else
        n_cmp++; if (o_err !== 2'd3) begin n_fail++; $display("FAIL f32_disabled error: got %0d want 3", o_err); end
        n_cmp++; if (o_cons !== 4'd0) begin n_fail++; $display("FAIL f32_disabled consumed: got %0d want 0", o_cons); end
        n_cmp++; if (o_acc !== 0) begin n_fail++; $display("FAIL f32_disabled accepted: got %0d want 0", o_acc); end
`endif
        tick();
    endtask

    task automatic test_bad_mode();
        for (int m = 6; m <= 7; m++) begin
            bv[0] = 8'h01;
            drive_decode(3'(m), 1, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
            n_cmp++; if (pc !== 1) begin n_fail++; $display("FAIL bad_mode%0d pulse_cycle: got %0d want 1", m, pc); end
            n_cmp++; if (o_err !== 2'd3) begin n_fail++; $display("FAIL bad_mode%0d error: got %0d want 3", m, o_err); end
            n_cmp++; if (o_cons !== 4'd0) begin n_fail++; $display("FAIL bad_mode%0d consumed: got %0d want 0", m, o_cons); end
            n_cmp++; if (o_acc !== 0) begin n_fail++; $display("FAIL bad_mode%0d accepted: got %0d want 0", m, o_acc); end
            tick();
        end
    endtask

    task automatic test_u32_boundary();
        for (int i = 0; i < 4; i++) bv[i] = 8'hFF;
        bv[4] = 8'h0F;
        drive_decode(3'd0, 5, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL u32_max imm: got %h want 00000000ffffffff", o_imm); end
        n_cmp++; if (o_cons !== 4'd5) begin n_fail++; $display("FAIL u32_max consumed: got %0d want 5", o_cons); end
        tick();
        bv[4] = 8'h1F;
        drive_decode(3'd0, 5, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd2) begin n_fail++; $display("FAIL u32_unused error: got %0d want 2", o_err); end
        n_cmp++; if (o_cons !== 4'd5) begin n_fail++; $display("FAIL u32_unused consumed: got %0d want 5", o_cons); end
        n_cmp++; if (o_imm !== 64'h0) begin n_fail++; $display("FAIL u32_unused imm: got %h want 0", o_imm); end
        tick();
        for (int i = 0; i < 6; i++) bv[i] = 8'h80;
        drive_decode(3'd0, 6, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd1) begin n_fail++; $display("FAIL u32_overlong error: got %0d want 1", o_err); end
        n_cmp++; if (pc !== 6) begin n_fail++; $display("FAIL u32_overlong pulse_cycle: got %0d want 6", pc); end
        n_cmp++; if (o_acc !== 5) begin n_fail++; $display("FAIL u32_overlong accepted: got %0d want 5", o_acc); end
        n_cmp++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL u32_overlong byte_ready: got %b want 0", o_rdy); end
        tick();
    endtask

    task automatic test_s32_boundary();
        for (int i = 0; i < 4; i++) bv[i] = 8'hFF;
        bv[4] = 8'h7F;
        drive_decode(3'd1, 5, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL s32_m1 imm: got %h want 00000000ffffffff", o_imm); end
        tick();
        bv[4] = 8'h4F;
        drive_decode(3'd1, 5, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd2) begin n_fail++; $display("FAIL s32_unused error: got %0d want 2", o_err); end
        tick();
    endtask

    task automatic test_64bit();
        for (int i = 0; i < 9; i++) bv[i] = 8'hFF;
        bv[9] = 8'h7F;
        drive_decode(3'd3, 10, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'hFFFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL s64_m1 imm: got %h want ffffffffffffffff", o_imm); end
        n_cmp++; if (o_cons !== 4'd10) begin n_fail++; $display("FAIL s64_m1 consumed: got %0d want 10", o_cons); end
        tick();
        bv[9] = 8'h01;
        drive_decode(3'd3, 10, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd2) begin n_fail++; $display("FAIL s64_unused error: got %0d want 2", o_err); end
        tick();
        drive_decode(3'd2, 10, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'hFFFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL u64_max imm: got %h want ffffffffffffffff", o_imm); end
        tick();
        bv[9] = 8'h02;
        drive_decode(3'd2, 10, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd2) begin n_fail++; $display("FAIL u64_unused error: got %0d want 2", o_err); end
        tick();
        bv[0] = 8'h40;
        drive_decode(3'd3, 1, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'hFFFFFFFF_FFFFFFC0) begin n_fail++; $display("FAIL s64_m64 imm: got %h want ffffffffffffffc0", o_imm); end
        tick();
        for (int i = 0; i < 11; i++) bv[i] = 8'h80;
        drive_decode(3'd3, 11, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_err !== 2'd1) begin n_fail++; $display("FAIL s64_overlong error: got %0d want 1", o_err); end
        n_cmp++; if (o_cons !== 4'd10) begin n_fail++; $display("FAIL s64_overlong consumed: got %0d want 10", o_cons); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_pulse;
        start = 1'b1; mode = 3'd0;
        tick();
        start = 1'b0;
        byte_valid = 1'b1; byte_data = 8'hE5;
        tick();
        byte_data = 8'h8E;
        tick();
        byte_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid byte_ready: got %b want 0", byte_ready); end
        n_cmp++; if (imm !== 64'h0) begin n_fail++; $display("FAIL rst_mid imm: got %h want 0", imm); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
        saw_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (imm_valid || (error != 2'd0)) saw_pulse = 1'b1;
            tick();
        end
        n_cmp++; if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid pulse: got %b want 0", saw_pulse); end
        bv[0] = 8'h05;
        drive_decode(3'd0, 1, -1, 0, pc, o_imm, o_cons, o_err, o_rdy, o_acc);
        n_cmp++; if (o_imm !== 64'h5) begin n_fail++; $display("FAIL rst_mid_restart imm: got %h want 5", o_imm); end
        n_cmp++; if (o_cons !== 4'd1) begin n_fail++; $display("FAIL rst_mid_restart consumed: got %0d want 1", o_cons); end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 3'd0; byte_data = 8'h00; byte_valid = 1'b0;
        test_reset();
        test_s32_single();
        test_u32_multi();
        test_s32_multi();
        test_float();
        test_bad_mode();
        test_u32_boundary();
        test_s32_boundary();
        test_64bit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
